// File: rtl/branch_predictor_unit.sv
// Direct-mapped BTB with 2-bit saturating counters: zero-latency IF lookup, EX-stage update and mispredict flush.
// Optional perf counters (BRANCH_COUNT, MISPREDICT_COUNT) are enabled with BP_PERF_COUNTERS_EN.
module branch_predictor_unit #(
    parameter int INDEX_BITS = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] PC_IF,
    output logic        PREDICT_TAKEN,
    output logic [31:0] PREDICT_TARGET,
    input  logic        UPDATE_EN,
    input  logic        UPDATE_JUMP,
    input  logic [31:0] PC_EX,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] TARGET_EX,
    input  logic        PRED_TAKEN_EX,
    input  logic [31:0] PRED_TARGET_EX,
    output logic        MISPREDICT,
    output logic [31:0] CORRECT_PC
`ifdef BP_PERF_COUNTERS_EN
    ,
    output logic [31:0] BRANCH_COUNT,
    output logic [31:0] MISPREDICT_COUNT
`endif
);

    localparam int ENTRIES  = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    logic [ENTRIES-1:0]  valid_reg;
    logic [TAG_BITS-1:0] tag_reg     [ENTRIES];
    logic [31:0]         target_reg  [ENTRIES];
    logic [1:0]          counter_reg [ENTRIES];

    logic [INDEX_BITS-1:0] if_idx;
    logic [TAG_BITS-1:0]   if_tag;
    logic                  if_hit;
    logic [INDEX_BITS-1:0] ex_idx;
    logic [TAG_BITS-1:0]   ex_tag;
    logic                  ex_hit;
    logic [1:0]            ex_counter;

    logic        upd_write;
    logic [1:0]  upd_counter;
    logic [31:0] upd_target;

    // Lookup reads the registered state directly, so a same-cycle update is not bypassed.
    assign if_idx = PC_IF[INDEX_BITS+1:2];
    assign if_tag = PC_IF[31:INDEX_BITS+2];
    assign if_hit = valid_reg[if_idx] && (tag_reg[if_idx] == if_tag);

    always_comb begin
        PREDICT_TAKEN  = if_hit && counter_reg[if_idx][1];
        PREDICT_TARGET = PREDICT_TAKEN ? target_reg[if_idx] : PC_IF + 32'd4;
    end

    always_comb begin
        MISPREDICT = 1'b0;
        CORRECT_PC = PC_EX + 32'd4;
        if (UPDATE_EN) begin
            if (BRANCH_TAKEN) begin
                CORRECT_PC = TARGET_EX;
            end
            MISPREDICT = (BRANCH_TAKEN != PRED_TAKEN_EX) ||
                         (BRANCH_TAKEN && PRED_TAKEN_EX && (TARGET_EX != PRED_TARGET_EX));
        end
    end

    assign ex_idx     = PC_EX[INDEX_BITS+1:2];
    assign ex_tag     = PC_EX[31:INDEX_BITS+2];
    assign ex_hit     = valid_reg[ex_idx] && (tag_reg[ex_idx] == ex_tag);
    assign ex_counter = counter_reg[ex_idx];

    // A jump reported as not taken is treated as a plain not-taken branch.
    always_comb begin
        upd_write   = 1'b0;
        upd_counter = ex_counter;
        upd_target  = target_reg[ex_idx];
        if (UPDATE_EN) begin
            if (ex_hit) begin
                upd_write = 1'b1;
                if (BRANCH_TAKEN && UPDATE_JUMP) begin
                    upd_counter = 2'b11;
                    upd_target  = TARGET_EX;
                end else if (BRANCH_TAKEN) begin
                    upd_counter = (ex_counter == 2'b11) ? 2'b11 : ex_counter + 2'd1;
                    upd_target  = TARGET_EX;
                end else begin
                    upd_counter = (ex_counter == 2'b00) ? 2'b00 : ex_counter - 2'd1;
                end
            end else if (BRANCH_TAKEN) begin
                upd_write   = 1'b1;
                upd_counter = UPDATE_JUMP ? 2'b11 : 2'b10;
                upd_target  = TARGET_EX;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_reg <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                counter_reg[i] <= 2'b01;
            end
        end else if (upd_write) begin
            valid_reg[ex_idx]   <= 1'b1;
            tag_reg[ex_idx]     <= ex_tag;
            target_reg[ex_idx]  <= upd_target;
            counter_reg[ex_idx] <= upd_counter;
        end
    end

`ifdef BP_PERF_COUNTERS_EN
    logic [31:0] branch_count_reg;
    logic [31:0] mispredict_count_reg;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            branch_count_reg     <= '0;
            mispredict_count_reg <= '0;
        end else begin
            if (UPDATE_EN) begin
                branch_count_reg <= branch_count_reg + 32'd1;
            end
            if (MISPREDICT) begin
                mispredict_count_reg <= mispredict_count_reg + 32'd1;
            end
        end
    end

    assign BRANCH_COUNT     = branch_count_reg;
    assign MISPREDICT_COUNT = mispredict_count_reg;
`endif

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Scoreboard bench for branch_predictor_unit: directed vectors push expectations, a negedge monitor pops and compares.
module tb_branch_predictor_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] PC_IF;
    logic        PREDICT_TAKEN;
    logic [31:0] PREDICT_TARGET;
    logic        UPDATE_EN;
    logic        UPDATE_JUMP;
    logic [31:0] PC_EX;
    logic        BRANCH_TAKEN;
    logic [31:0] TARGET_EX;
    logic        PRED_TAKEN_EX;
    logic [31:0] PRED_TARGET_EX;
    logic        MISPREDICT;
    logic [31:0] CORRECT_PC;
`ifdef BP_PERF_COUNTERS_EN
    logic [31:0] BRANCH_COUNT;
    logic [31:0] MISPREDICT_COUNT;
`endif

    branch_predictor_unit #(.INDEX_BITS(4)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .PC_IF(PC_IF),
        .PREDICT_TAKEN(PREDICT_TAKEN),
        .PREDICT_TARGET(PREDICT_TARGET),
        .UPDATE_EN(UPDATE_EN),
        .UPDATE_JUMP(UPDATE_JUMP),
        .PC_EX(PC_EX),
        .BRANCH_TAKEN(BRANCH_TAKEN),
        .TARGET_EX(TARGET_EX),
        .PRED_TAKEN_EX(PRED_TAKEN_EX),
        .PRED_TARGET_EX(PRED_TARGET_EX),
        .MISPREDICT(MISPREDICT),
        .CORRECT_PC(CORRECT_PC)
`ifdef BP_PERF_COUNTERS_EN
        ,
        .BRANCH_COUNT(BRANCH_COUNT),
        .MISPREDICT_COUNT(MISPREDICT_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          kind;   // 0 lookup, 1 mispredict, 2 perf counters
        logic [31:0] a;
        logic [31:0] b;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always @(negedge CLK) begin
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            case (e.kind)
                0: begin
                    if ({31'd0, PREDICT_TAKEN} !== e.a || PREDICT_TARGET !== e.b) begin
                        errors++;
                        $display("FAIL %s: got taken=%0d target=%08h, want taken=%0d target=%08h",
                                 e.name, PREDICT_TAKEN, PREDICT_TARGET, e.a[0], e.b);
                    end else begin
                        $display("ok   %s: taken=%0d target=%08h", e.name, PREDICT_TAKEN, PREDICT_TARGET);
                    end
                end
                1: begin
                    if ({31'd0, MISPREDICT} !== e.a || CORRECT_PC !== e.b) begin
                        errors++;
                        $display("FAIL %s: got mispredict=%0d correct_pc=%08h, want mispredict=%0d correct_pc=%08h",
                                 e.name, MISPREDICT, CORRECT_PC, e.a[0], e.b);
                    end else begin
                        $display("ok   %s: mispredict=%0d correct_pc=%08h", e.name, MISPREDICT, CORRECT_PC);
                    end
                end
                default: begin
`ifdef BP_PERF_COUNTERS_EN
                    if (BRANCH_COUNT !== e.a || MISPREDICT_COUNT !== e.b) begin
                        errors++;
                        $display("FAIL %s: got branches=%0d mispredicts=%0d, want branches=%0d mispredicts=%0d",
                                 e.name, BRANCH_COUNT, MISPREDICT_COUNT, e.a, e.b);
                    end else begin
                        $display("ok   %s: branches=%0d mispredicts=%0d", e.name, BRANCH_COUNT, MISPREDICT_COUNT);
                    end
`else
                    errors++;
                    $display("FAIL %s: perf expectation queued without perf counters", e.name);
`endif
                end
            endcase
        end
    end

    task automatic step(input logic [31:0] pc_if, input logic en, input logic jump,
                        input logic [31:0] pc_ex, input logic taken, input logic [31:0] tgt,
                        input logic ptaken, input logic [31:0] ptgt);
        @(posedge CLK);
        #1;
        PC_IF          = pc_if;
        UPDATE_EN      = en;
        UPDATE_JUMP    = jump;
        PC_EX          = pc_ex;
        BRANCH_TAKEN   = taken;
        TARGET_EX      = tgt;
        PRED_TAKEN_EX  = ptaken;
        PRED_TARGET_EX = ptgt;
    endtask

    task automatic look(input logic [31:0] pc);
        step(pc, 1'b0, 1'b0, 32'h0000_1000, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic exp_look(input logic taken, input logic [31:0] tgt, input string name);
        exp_t e;
        e.kind = 0; e.a = {31'd0, taken}; e.b = tgt; e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic exp_misp(input logic m, input logic [31:0] cpc, input string name);
        exp_t e;
        e.kind = 1; e.a = {31'd0, m}; e.b = cpc; e.name = name;
        sb_q.push_back(e);
    endtask

`ifdef BP_PERF_COUNTERS_EN
    task automatic exp_perf(input logic [31:0] br, input logic [31:0] mp, input string name);
        exp_t e;
        e.kind = 2; e.a = br; e.b = mp; e.name = name;
        sb_q.push_back(e);
    endtask
`endif

    initial begin
        RESET = 1'b1;
        PC_IF = 32'h40; UPDATE_EN = 1'b0; UPDATE_JUMP = 1'b0; PC_EX = 32'h0;
        BRANCH_TAKEN = 1'b0; TARGET_EX = 32'h0; PRED_TAKEN_EX = 1'b0; PRED_TARGET_EX = 32'h0;

        // During reset the cleared table yields a miss
        look(32'h40);                 exp_look(1'b0, 32'h44, "in_reset_lookup");
        step(32'h40, 1'b0, 1'b0, 32'h1000, 1'b0, 32'h0, 1'b0, 32'h0);
        RESET = 1'b0;
        exp_look(1'b0, 32'h44, "reset_lookup_0x40");
        exp_misp(1'b0, 32'h1004, "idle_no_mispredict");
        look(32'hFFFF_FFFC);          exp_look(1'b0, 32'h0, "pc_plus4_wrap");

        // Allocate 0x40 -> 0x100; same-cycle lookup still sees the old contents
        step(32'h40, 1'b1, 1'b0, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        exp_misp(1'b1, 32'h100, "alloc_mispredict");
        exp_look(1'b0, 32'h44, "no_bypass_same_cycle");
        look(32'h40);                 exp_look(1'b1, 32'h100, "alloc_hit_ctr10");

        // Not-taken twice: 10 -> 01 -> 00
        step(32'h40, 1'b1, 1'b0, 32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
        exp_misp(1'b1, 32'h44, "nt1_mispredict");
        step(32'h40, 1'b1, 1'b0, 32'h40, 1'b0, 32'h100, 1'b0, 32'h0);
        exp_misp(1'b0, 32'h44, "nt2_correct");
        exp_look(1'b0, 32'h44, "ctr01_not_taken");
        look(32'h40);                 exp_look(1'b0, 32'h44, "ctr00_not_taken");

        // Three taken: 00 -> 01 -> 10 -> 11, then a fourth saturates
        step(32'h40, 1'b1, 1'b0, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        exp_misp(1'b1, 32'h100, "t1_mispredict");
        step(32'h40, 1'b1, 1'b0, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        exp_look(1'b0, 32'h44, "ctr01_still_nt");
        look(32'h40);                 exp_look(1'b1, 32'h100, "ctr10_taken");
        step(32'h40, 1'b1, 1'b0, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        step(32'h40, 1'b1, 1'b0, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
        exp_misp(1'b0, 32'h100, "t4_target_match");
        step(32'h40, 1'b1, 1'b0, 32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
        exp_misp(1'b1, 32'h44, "nt_after_sat");
        look(32'h40);                 exp_look(1'b1, 32'h100, "saturated_then_ctr10");

        // Aliasing: 0x80 shares index 0 with 0x40
        step(32'h40, 1'b1, 1'b0, 32'h80, 1'b1, 32'h180, 1'b0, 32'h0);
        exp_misp(1'b1, 32'h180, "alias_alloc");
        look(32'h40);                 exp_look(1'b0, 32'h44, "alias_old_misses");
        look(32'h80);                 exp_look(1'b1, 32'h180, "alias_new_hits");

        // JALR at 0x200 with a wrong predicted target
        step(32'h80, 1'b1, 1'b1, 32'h200, 1'b1, 32'h340, 1'b1, 32'h300);
        exp_misp(1'b1, 32'h340, "jalr_target_mispredict");
        look(32'h200);                exp_look(1'b1, 32'h340, "jalr_entry");
        step(32'h200, 1'b1, 1'b0, 32'h200, 1'b0, 32'h340, 1'b1, 32'h340);
        exp_misp(1'b1, 32'h204, "jalr_site_not_taken");
        step(32'h200, 1'b1, 1'b1, 32'h200, 1'b1, 32'h380, 1'b1, 32'h340);
        exp_look(1'b1, 32'h340, "ctr10_after_nt");
        exp_misp(1'b1, 32'h380, "jal_hit_new_target");
        step(32'h200, 1'b1, 1'b0, 32'h200, 1'b0, 32'h380, 1'b1, 32'h380);
        exp_look(1'b1, 32'h380, "jal_hit_ctr11");
        look(32'h200);                exp_look(1'b1, 32'h380, "ctr11_minus1_taken");

        // Reset coincident with an update at 0x44 discards the write
        step(32'h44, 1'b1, 1'b0, 32'h44, 1'b1, 32'h500, 1'b0, 32'h0);
        RESET = 1'b1;
        look(32'h44);
        RESET = 1'b0;
        exp_look(1'b0, 32'h48, "reset_drops_update");
        look(32'h200);                exp_look(1'b0, 32'h204, "reset_clears_entries");
`ifdef BP_PERF_COUNTERS_EN
        exp_perf(32'd0, 32'd0, "perf_after_reset");
`endif

        // Five updates, two mispredicts
        step(32'h44, 1'b1, 1'b0, 32'h44, 1'b1, 32'h500, 1'b0, 32'h0);
        exp_misp(1'b1, 32'h500, "p1_alloc");
        step(32'h44, 1'b1, 1'b0, 32'h44, 1'b1, 32'h500, 1'b1, 32'h500);
        exp_misp(1'b0, 32'h500, "p2_hit");
        step(32'h44, 1'b1, 1'b0, 32'h44, 1'b1, 32'h500, 1'b1, 32'h500);
        exp_misp(1'b0, 32'h500, "p3_hit");
        step(32'h44, 1'b1, 1'b0, 32'h44, 1'b0, 32'h500, 1'b1, 32'h500);
        exp_misp(1'b1, 32'h48, "p4_nt");
        step(32'h44, 1'b1, 1'b0, 32'h44, 1'b0, 32'h500, 1'b0, 32'h0);
        exp_misp(1'b0, 32'h48, "p5_nt");
        look(32'h44);                 exp_look(1'b0, 32'h48, "p_final_ctr01");
`ifdef BP_PERF_COUNTERS_EN
        exp_perf(32'd5, 32'd2, "perf_counts");
        look(32'h44);
        RESET = 1'b1;
        look(32'h44);
        RESET = 1'b0;
        exp_perf(32'd0, 32'd0, "perf_cleared");
`endif

        look(32'h0);
        @(posedge CLK);
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
